adxl_sequencer: RTL and testbench
=================================

Name: adxl_sequencer

Overview:
Command sequencer that owns the SPI byte engine used for the ADXL362 accelerometer. After reset it waits out sensor power-up, runs a fixed init script (soft reset, FIFO disable, measurement mode), then periodically issues burst reads of XDATA/YDATA/ZDATA (regs 0x08-0x0A). It sits between the top-level/display logic (sample outputs) and the byte-level SPI engine (start/done handshake), replacing the hard-coded per-command tables in the current master.

Parameters:
POWERUP_CYCLES, 100000, clk cycles between reset release and first frame (1 ms at 100 MHz)
SRST_WAIT_CYCLES, 50000, idle cycles after the soft-reset frame before the next frame
GAP_CYCLES, 20, minimum clk cycles of CS-high between any two frames
SAMPLE_CYCLES, 1000000, period between read-frame starts (100 Hz at 100 MHz); must exceed one read frame plus GAP_CYCLES
TIMEOUT_CYCLES, 4096, max clk cycles from spi_start to spi_done before an error is declared

Ports:
clk  in  1  100 MHz system clock
rst  in  1  synchronous active-high reset
enable  in  1  when 0, no new frame starts; an in-flight frame completes and the block parks in IDLE
spi_busy  in  1  byte engine busy; spi_start is only issued while 0
spi_done  in  1  one-cycle pulse: current byte shifted, spi_rx valid this cycle
spi_rx  in  8  byte received during the completed transfer
spi_start  out  1  one-cycle pulse requesting one byte transfer
spi_tx  out  8  byte to send; stable from spi_start until spi_done
spi_hold  out  1  1 = keep CS low after this byte (more bytes in frame); 0 = last byte, engine releases CS
init_done  out  1  level, set after the measurement-mode frame completes
sample_valid  out  1  one-cycle pulse; x/y/z_data updated the same cycle
x_data  out  8  latest XDATA
y_data  out  8  latest YDATA
z_data  out  8  latest ZDATA
error  out  1  sticky until rst; set on spi_done timeout

Behaviour:
- Reset: all outputs 0; state PWRUP; wait counter cleared. Reset mid-frame aborts immediately; spi_start is not reissued until PWRUP expires.
- States: PWRUP -> INIT_BYTE -> INIT_WAIT -> (GAP | SRST_WAIT) -> ... -> IDLE -> RD_BYTE -> RD_WAIT -> PUBLISH -> IDLE; ERROR.
- PWRUP: count POWERUP_CYCLES, then INIT_BYTE at frame 0, byte 0.
- Init script ROM (frame: bytes): F0 0x0A,0x1F,0x52 (soft reset); F1 0x0A,0x28,0x00 (FIFO off); F2 0x0A,0x2D,0x02 (measure). spi_hold = 1 for bytes 0-1, 0 for byte 2.
- INIT_BYTE: when spi_busy=0 assert spi_start for exactly 1 cycle with spi_tx/spi_hold from ROM, go INIT_WAIT. On spi_done: next byte if any; else after F0 go SRST_WAIT (SRST_WAIT_CYCLES), after F1 go GAP (GAP_CYCLES), after F2 set init_done and go IDLE.
- Read frame: 0x0B, 0x08, 0x00, 0x00, 0x00; spi_hold = 1 for bytes 0-3, 0 for byte 4. spi_rx at bytes 2,3,4 captured into shadow X,Y,Z; bytes 0-1 rx ignored.
- PUBLISH: one cycle; copy shadows to x/y/z_data, pulse sample_valid. Outputs hold otherwise.
- IDLE: sample timer free-runs from the first read start, reloading every SAMPLE_CYCLES; a read starts on timer expiry if enable=1 and the GAP since the last frame has elapsed. Expiry while enable=0 is dropped (no queued read). First read starts GAP_CYCLES after init_done.
- enable=0 during PWRUP/init: init script still runs to completion; only reads are gated.
- Timeout: counter runs in *_WAIT; reaching TIMEOUT_CYCLES -> set error, clear init_done, go ERROR, which waits POWERUP_CYCLES then restarts the init script at F0 (full reinit). x/y/z_data retained.
- spi_done outside a *_WAIT state is ignored. At most one byte outstanding.
- Counters sized for the largest parameter, no wrap hazards; byte index 3 bits.

Test Plan:
- Reset release, engine model with 16-cycle byte latency -> first spi_start at cycle POWERUP_CYCLES; spi_tx sequence 0A 1F 52 | 0A 28 00 | 0A 2D 02, hold 1,1,0 per frame; F0->F1 start gap >= SRST_WAIT_CYCLES; init_done high after 9th spi_done.
- Model returns rx 0x12,0x34,0x56 on read bytes 2-4 -> sample_valid single pulse, x=0x12 y=0x34 z=0x56; read tx 0B 08 00 00 00, hold 1,1,1,1,0.
- SAMPLE_CYCLES=2000 shrunk, run 5 periods -> read-frame starts exactly 2000 cycles apart, 5 sample_valid pulses.
- enable=0 across two expiries, then 1 -> no frames while low, next read at following expiry, frame in flight when enable fell completes with sample_valid.
- Model withholds spi_done on F1 byte 1 -> error=1 at TIMEOUT_CYCLES after that spi_start, init_done=0, reinit from 0x0A 0x1F after POWERUP_CYCLES; error stays 1.
- rst asserted during read byte 3 -> all outputs 0 next cycle, no spi_start for POWERUP_CYCLES, init repeats in full.

Source files
------------

// File: rtl/adxl_sequencer.sv
// adxl_sequencer
// ---------------------------------------------------------------------------
// Command sequencer in front of the byte-level SPI engine that talks to the
// ADXL362. After reset it waits out sensor power-up, plays a three-frame init
// script (soft reset, FIFO off, measurement mode), then issues a periodic
// burst read of XDATA/YDATA/ZDATA (0x08-0x0A) and publishes the three bytes.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   enable        gates the start of read frames (init always runs)
//   spi_busy      engine busy; a new byte is only requested while low
//   spi_done      one-cycle pulse, byte finished, spi_rx valid
//   spi_rx[7:0]   received byte
//   spi_start     one-cycle byte request
//   spi_tx[7:0]   byte to send, held from spi_start until spi_done
//   spi_hold      1 = keep CS low after this byte, 0 = last byte of frame
//   init_done     level, init script complete
//   sample_valid  one-cycle pulse, x/y/z_data updated in the same cycle
//   x/y/z_data    latest axis samples (retained across error recovery)
//   error         sticky spi_done timeout flag, cleared only by rst
//   state_dbg     current FSM state encoding
//
// Engine handshake: spi_start is a single-cycle request issued only while
// spi_busy is low; the sequencer then keeps spi_tx/spi_hold stable and waits
// in a *_WAIT state for exactly one spi_done. Only one byte is ever
// outstanding, and spi_done seen in any other state is ignored.
// ---------------------------------------------------------------------------
module adxl_sequencer #(
    parameter int POWERUP_CYCLES   = 100000,
    parameter int SRST_WAIT_CYCLES = 50000,
    parameter int GAP_CYCLES       = 20,
    parameter int SAMPLE_CYCLES    = 1000000,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       spi_busy,
    input  logic       spi_done,
    input  logic [7:0] spi_rx,
    output logic       spi_start,
    output logic [7:0] spi_tx,
    output logic       spi_hold,
    output logic       init_done,
    output logic       sample_valid,
    output logic [7:0] x_data,
    output logic [7:0] y_data,
    output logic [7:0] z_data,
    output logic       error,
    output logic [3:0] state_dbg
);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int WAIT_MAX = max_int(max_int(POWERUP_CYCLES, SRST_WAIT_CYCLES),
                                      max_int(GAP_CYCLES, TIMEOUT_CYCLES));
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int SAMP_W   = $clog2(SAMPLE_CYCLES + 1);
    localparam int GAP_W    = $clog2(GAP_CYCLES + 1);

    typedef enum logic [3:0] {
        S_PWRUP     = 4'd0,
        S_INIT_BYTE = 4'd1,
        S_INIT_WAIT = 4'd2,
        S_SRST_WAIT = 4'd3,
        S_GAP       = 4'd4,
        S_IDLE      = 4'd5,
        S_RD_BYTE   = 4'd6,
        S_RD_WAIT   = 4'd7,
        S_PUBLISH   = 4'd8,
        S_ERROR     = 4'd9
    } state_t;

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [SAMP_W-1:0] samp_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              timer_run;
    logic [1:0]        frame_idx;
    logic [2:0]        byte_idx;
    logic [7:0]        x_shadow, y_shadow, z_shadow;

    logic timer_expire, gap_ok, start_read;
    logic last_init_byte, last_read_byte, wait_timeout;

    assign state_dbg = state;

    // Init script: 3 frames of 3 bytes (write command, register, value).
    function automatic logic [7:0] init_rom(input logic [1:0] f, input logic [2:0] b);
        logic [7:0] v;
        v = 8'h00;
        if (b == 3'd0)      v = 8'h0A;
        else if (b == 3'd1) v = (f == 2'd0) ? 8'h1F : (f == 2'd1) ? 8'h28 : 8'h2D;
        else if (b == 3'd2) v = (f == 2'd0) ? 8'h52 : (f == 2'd1) ? 8'h00 : 8'h02;
        return v;
    endfunction

    // Burst read: read command, start address XDATA, three dummy bytes.
    function automatic logic [7:0] read_rom(input logic [2:0] b);
        logic [7:0] v;
        v = 8'h00;
        if (b == 3'd0)      v = 8'h0B;
        else if (b == 3'd1) v = 8'h08;
        return v;
    endfunction

    always_comb begin
        timer_expire   = timer_run && (samp_cnt == SAMP_W'(SAMPLE_CYCLES - 1));
        gap_ok         = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
        // Before the first read the timer is not running, so the read only
        // waits for the CS-high gap; afterwards it waits for timer expiry.
        start_read     = enable && gap_ok && (!timer_run || timer_expire);
        last_init_byte = (byte_idx == 3'd2);
        last_read_byte = (byte_idx == 3'd4);
        wait_timeout   = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        next_state = state;
        spi_start  = 1'b0;
        spi_tx     = 8'h00;
        spi_hold   = 1'b0;
        case (state)
            S_PWRUP, S_ERROR: begin
                if (wait_cnt == WAIT_W'(POWERUP_CYCLES - 1)) next_state = S_INIT_BYTE;
            end
            S_INIT_BYTE: begin
                spi_tx   = init_rom(frame_idx, byte_idx);
                spi_hold = !last_init_byte;
                if (!spi_busy) begin
                    spi_start  = 1'b1;
                    next_state = S_INIT_WAIT;
                end
            end
            S_INIT_WAIT: begin
                spi_tx   = init_rom(frame_idx, byte_idx);
                spi_hold = !last_init_byte;
                if (spi_done) begin
                    if (!last_init_byte)         next_state = S_INIT_BYTE;
                    else if (frame_idx == 2'd0)  next_state = S_SRST_WAIT;
                    else if (frame_idx == 2'd1)  next_state = S_GAP;
                    else                         next_state = S_IDLE;
                end else if (wait_timeout) begin
                    next_state = S_ERROR;
                end
            end
            S_SRST_WAIT: begin
                if (wait_cnt == WAIT_W'(SRST_WAIT_CYCLES - 1)) next_state = S_INIT_BYTE;
            end
            S_GAP: begin
                if (wait_cnt == WAIT_W'(GAP_CYCLES - 1)) next_state = S_INIT_BYTE;
            end
            S_IDLE: begin
                if (start_read) next_state = S_RD_BYTE;
            end
            S_RD_BYTE: begin
                spi_tx   = read_rom(byte_idx);
                spi_hold = !last_read_byte;
                if (!spi_busy) begin
                    spi_start  = 1'b1;
                    next_state = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                spi_tx   = read_rom(byte_idx);
                spi_hold = !last_read_byte;
                if (spi_done)          next_state = last_read_byte ? S_PUBLISH : S_RD_BYTE;
                else if (wait_timeout) next_state = S_ERROR;
            end
            S_PUBLISH: next_state = S_IDLE;
            default:   next_state = S_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_PWRUP;
            wait_cnt     <= '0;
            samp_cnt     <= '0;
            gap_cnt      <= '0;
            timer_run    <= 1'b0;
            frame_idx    <= '0;
            byte_idx     <= '0;
            x_shadow     <= 8'h00;
            y_shadow     <= 8'h00;
            z_shadow     <= 8'h00;
            x_data       <= 8'h00;
            y_data       <= 8'h00;
            z_data       <= 8'h00;
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
            error        <= 1'b0;
        end else begin
            state <= next_state;

            // The cycle carrying spi_start already counts toward the timeout,
            // so the count starts at 1 on entry to a *_WAIT state.
            if (next_state != state)
                wait_cnt <= (next_state == S_INIT_WAIT || next_state == S_RD_WAIT)
                            ? WAIT_W'(1) : '0;
            else if (wait_cnt != WAIT_W'(WAIT_MAX))
                wait_cnt <= wait_cnt + 1'b1;

            // CS-high gap: cleared whenever a frame may hold CS low.
            if (state inside {S_INIT_BYTE, S_INIT_WAIT, S_RD_BYTE, S_RD_WAIT})
                gap_cnt <= '0;
            else if (!gap_ok)
                gap_cnt <= gap_cnt + 1'b1;

            // Sample timer free-runs once the first read has started; an
            // expiry that cannot start a read is simply lost.
            if (next_state == S_ERROR) begin
                timer_run <= 1'b0;
                samp_cnt  <= '0;
            end else if (state == S_IDLE && start_read) begin
                timer_run <= 1'b1;
                samp_cnt  <= '0;
            end else if (timer_run) begin
                samp_cnt <= timer_expire ? '0 : samp_cnt + 1'b1;
            end

            case (state)
                S_PWRUP, S_ERROR: begin
                    frame_idx <= '0;
                    byte_idx  <= '0;
                end
                S_INIT_WAIT: begin
                    if (spi_done) begin
                        if (last_init_byte) begin
                            byte_idx  <= '0;
                            frame_idx <= frame_idx + 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                S_IDLE: byte_idx <= '0;
                S_RD_WAIT: begin
                    if (spi_done) begin
                        byte_idx <= byte_idx + 1'b1;
                        case (byte_idx)
                            3'd2:    x_shadow <= spi_rx;
                            3'd3:    y_shadow <= spi_rx;
                            3'd4:    z_shadow <= spi_rx;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase

            sample_valid <= (state == S_PUBLISH);
            if (state == S_PUBLISH) begin
                x_data <= x_shadow;
                y_data <= y_shadow;
                z_data <= z_shadow;
            end

            if (next_state == S_ERROR)
                init_done <= 1'b0;
            else if (state == S_INIT_WAIT && spi_done && last_init_byte && frame_idx == 2'd2)
                init_done <= 1'b1;

            if (next_state == S_ERROR)
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adxl_sequencer.sv
// Testbench for adxl_sequencer: a behavioural SPI byte engine with a fixed
// 16-cycle byte latency, a transfer log, and a scoreboard of expected
// x/y/z samples. Parameters are shrunk so the whole run stays short.
module tb_adxl_sequencer;

    localparam int P    = 200;
    localparam int SRST = 100;
    localparam int GAP  = 20;
    localparam int SAMP = 2000;
    localparam int TMO  = 300;
    localparam int LAT  = 16;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       spi_busy = 1'b0;
    logic       spi_done = 1'b0;
    logic [7:0] spi_rx = 8'h00;
    logic       spi_start, spi_hold, init_done, sample_valid, error;
    logic [7:0] spi_tx, x_data, y_data, z_data;
    logic [3:0] state_dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    adxl_sequencer #(
        .POWERUP_CYCLES   (P),
        .SRST_WAIT_CYCLES (SRST),
        .GAP_CYCLES       (GAP),
        .SAMPLE_CYCLES    (SAMP),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .spi_busy     (spi_busy),
        .spi_done     (spi_done),
        .spi_rx       (spi_rx),
        .spi_start    (spi_start),
        .spi_tx       (spi_tx),
        .spi_hold     (spi_hold),
        .init_done    (init_done),
        .sample_valid (sample_valid),
        .x_data       (x_data),
        .y_data       (y_data),
        .z_data       (z_data),
        .error        (error),
        .state_dbg    (state_dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference byte streams as {hold, tx}.
    logic [8:0] init_seq [9] = '{9'h10A, 9'h11F, 9'h052,
                                 9'h10A, 9'h128, 9'h000,
                                 9'h10A, 9'h12D, 9'h002};
    logic [8:0] rd_seq [5]   = '{9'h10B, 9'h108, 9'h100, 9'h100, 9'h000};

    // ---------------- SPI engine model + transfer log ----------------
    int         st_cyc  [256];
    logic [8:0] st_byte [256];
    int         dn_cyc  [256];
    int         n_st = 0;
    int         eng_cnt = 0;
    int         eng_idx = 0;
    int         frm_pos = 0;
    int         withhold_idx = -1;
    bit         first_read = 1'b1;
    bit         in_read = 1'b0;
    logic [7:0] rx_x = 8'h00, rx_y = 8'h00, rx_z = 8'h00;
    logic [23:0] exp_q[$];

    always @(negedge clk) begin
        spi_done = 1'b0;
        if (rst) begin
            eng_cnt  = 0;
            spi_busy = 1'b0;
            frm_pos  = 0;
            spi_rx   = 8'h00;
            exp_q.delete();
        end else if (eng_cnt != 0) begin
            check_val("start_while_busy", {31'd0, spi_start}, 32'd0);
            eng_cnt--;
            spi_busy = (eng_cnt != 0);
            if (eng_cnt == 0) begin
                if (eng_idx == withhold_idx) begin
                    frm_pos = 0;
                end else begin
                    check_val("tx_stable", {23'd0, spi_hold, spi_tx}, {23'd0, st_byte[eng_idx]});
                    dn_cyc[eng_idx] = cyc;
                    spi_done = 1'b1;
                    case (frm_pos)
                        2:       spi_rx = rx_x;
                        3:       spi_rx = rx_y;
                        4:       spi_rx = rx_z;
                        default: spi_rx = 8'($urandom_range(0, 255));
                    endcase
                    if (in_read && frm_pos == 4) exp_q.push_back({rx_x, rx_y, rx_z});
                    frm_pos = st_byte[eng_idx][8] ? frm_pos + 1 : 0;
                end
            end
        end else if (spi_start) begin
            if (n_st < 256) begin
                st_cyc[n_st]  = cyc;
                st_byte[n_st] = {spi_hold, spi_tx};
            end
            eng_idx = n_st;
            n_st++;
            eng_cnt = LAT;
            if (frm_pos == 0) begin
                in_read = (spi_tx == 8'h0B);
                if (in_read) begin
                    if (first_read) begin
                        rx_x = 8'h12; rx_y = 8'h34; rx_z = 8'h56;
                        first_read = 1'b0;
                    end else begin
                        rx_x = 8'($urandom_range(0, 255));
                        rx_y = 8'($urandom_range(0, 255));
                        rx_z = 8'($urandom_range(0, 255));
                    end
                end
            end
        end
    end

    // ---------------- sample scoreboard ----------------
    int n_sv = 0;
    bit sv_prev = 1'b0;
    bit init_prev = 1'b0;
    int init_rise = 0;

    always @(negedge clk) begin
        if (!rst && sample_valid) begin
            n_sv++;
            check_val("sv_single_pulse", {31'd0, sv_prev}, 32'd0);
            check_val("sb_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() != 0)
                check_val("sample_xyz", {8'd0, x_data, y_data, z_data}, {8'd0, exp_q.pop_front()});
        end
        if (init_done && !init_prev) init_rise = cyc;
        init_prev = init_done;
        sv_prev   = sample_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_starts(input int n, input int budget, input string tag);
        int k = 0;
        while (n_st < n && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        check_val(tag, 32'(n_st >= n), 32'd1);
    endtask

    task automatic wait_sv(input int n, input int budget, input string tag);
        int k = 0;
        while (n_sv < n && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        check_val(tag, 32'(n_sv >= n), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rel, rel2, base2, s6, sv_before, err_cyc, k;

        rst = 1'b1;
        enable = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check_val("rst_ctrl", {27'd0, spi_start, spi_hold, init_done, sample_valid, error}, 32'd0);
        check_val("rst_data", {spi_tx, x_data, y_data, z_data}, 32'd0);
        rst = 1'b0;
        rel = cyc;

        // Init script plus five read frames.
        wait_starts(9 + 25, 20000, "wait_init_and_reads");
        wait_sv(5, 3000, "wait_five_samples");
        check_val("first_start_delay", st_cyc[0] - rel, P);
        for (int i = 0; i < 9; i++)
            check_val($sformatf("init_byte%0d", i), {23'd0, st_byte[i]}, {23'd0, init_seq[i]});
        check_val("srst_wait_gap", 32'((st_cyc[3] - dn_cyc[2]) >= SRST), 32'd1);
        check_val("f1_f2_gap", 32'((st_cyc[6] - dn_cyc[5]) >= GAP), 32'd1);
        check_val("init_done_after_9th_done", init_rise - dn_cyc[8], 32'd1);
        check_val("first_read_delay", st_cyc[9] - init_rise, GAP);
        for (int f = 0; f < 5; f++)
            for (int b = 0; b < 5; b++)
                check_val($sformatf("read%0d_byte%0d", f, b),
                          {23'd0, st_byte[9 + 5*f + b]}, {23'd0, rd_seq[b]});
        for (int f = 1; f < 5; f++)
            check_val($sformatf("read_period%0d", f), st_cyc[9 + 5*f] - st_cyc[9 + 5*(f-1)], SAMP);
        check_val("sample_count", n_sv, 5);

        // Drop enable during frame 6 and hold it low across two expiries.
        wait_starts(35, SAMP + 500, "wait_frame6");
        s6 = st_cyc[34];
        repeat (2) @(posedge clk);
        #2;
        sv_before = n_sv;
        enable = 1'b0;
        while (cyc < s6 + 2*SAMP + 1000) begin
            @(posedge clk); #2;
        end
        check_val("no_frames_while_disabled", n_st, 39);
        check_val("inflight_frame_published", n_sv, sv_before + 1);
        enable = 1'b1;
        wait_starts(40, SAMP, "wait_frame7");
        check_val("resume_on_next_expiry", st_cyc[39] - s6, 3*SAMP);
        check_val("resume_byte0", {23'd0, st_byte[39]}, {23'd0, rd_seq[0]});

        // Reset in the middle of read byte 3.
        wait_starts(43, 200, "wait_frame7_byte3");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        check_val("midframe_rst_ctrl", {27'd0, spi_start, spi_hold, init_done, sample_valid, error}, 32'd0);
        check_val("midframe_rst_data", {spi_tx, x_data, y_data, z_data}, 32'd0);
        base2 = n_st;
        withhold_idx = base2 + 4;   // F1 byte 1 of the repeated init
        rst = 1'b0;
        rel2 = cyc;

        wait_starts(base2 + 5, P + 400, "wait_reinit_f1");
        check_val("reinit_start_delay", st_cyc[base2] - rel2, P);
        for (int i = 0; i < 5; i++)
            check_val($sformatf("reinit_byte%0d", i), {23'd0, st_byte[base2 + i]}, {23'd0, init_seq[i]});

        // spi_done withheld: expect timeout error and full reinit.
        k = 0;
        while (!error && k < TMO + 100) begin
            @(posedge clk); #2;
            k++;
        end
        err_cyc = cyc;
        check_val("error_set", {31'd0, error}, 32'd1);
        check_val("timeout_latency", err_cyc - st_cyc[base2 + 4], TMO);
        check_val("init_done_cleared", {31'd0, init_done}, 32'd0);
        wait_starts(base2 + 7, P + 100, "wait_error_reinit");
        check_val("error_reinit_delay", st_cyc[base2 + 5] - err_cyc, P);
        check_val("error_reinit_byte0", {23'd0, st_byte[base2 + 5]}, {23'd0, init_seq[0]});
        check_val("error_reinit_byte1", {23'd0, st_byte[base2 + 6]}, {23'd0, init_seq[1]});

        sv_before = n_sv;
        wait_starts(base2 + 5 + 9 + 5, 1500, "wait_read_after_error");
        wait_sv(sv_before + 1, 300, "wait_sample_after_error");
        check_val("init_done_after_reinit", {31'd0, init_done}, 32'd1);
        check_val("error_sticky", {31'd0, error}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
